seq_detect_rr_sched: RTL and testbench
======================================

// Module: seq_detect_rr_sched
// PURPOSE
//  Round-robin scheduler that shares one serial "1001" non-overlapping Mealy detector among NREQ requesters.
//  Each grant latches a WIDTH-bit word from the winner and shifts it MSB-first through the detector.
//  On completion, reports the requester id and the number of matches found in that word.
//  Sits between parallel byte sources and the serial pattern-detection datapath.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  WIDTH  8  bits per word shifted per grant
//  CNTW   3  width of match_cnt; count saturates at all-ones
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           asynchronous reset, active-low
//  en         in   1           shift enable; 0 freezes an in-flight word
//  req        in   NREQ        per-requester request level, held until gnt
//  data       in   NREQ*WIDTH  word i = data[i*WIDTH +: WIDTH]
//  gnt        out  NREQ        one-hot grant, one-cycle pulse
//  busy       out  1           1 while a word is being shifted
//  ser_out    out  1           current serial bit (shreg MSB)
//  ser_valid  out  1           1 when ser_out is consumed at the next edge (busy & en)
//  done       out  1           one-cycle pulse: result valid
//  done_id    out  clog2(NREQ) requester id of the finished word, held until next done
//  match_cnt  out  CNTW        matches in the finished word, held until next done
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0; ctrl state IDLE; detector S0; rr pointer 0; shreg and bit counter 0.
//  Ctrl FSM:
//   - IDLE: at an edge with any req bit set, pick the first set bit searching from ptr upward (wrapping).
//     On that edge: shreg<=word; gnt<=onehot(i); id<=i; bitcnt<=0; det<=S0; cnt<=0; state<=SHIFT.
//     ptr<=(i+1)%NREQ.
//   - SHIFT: gnt is high only during the first SHIFT cycle. busy=1.
//     Each edge with en=1: the detector consumes ser_out, shreg shifts left, and bitcnt increments.
//     en=0: shreg, bitcnt, detector state and cnt all hold.
//     At the edge consuming bit WIDTH-1: done<=1, done_id<=id, match_cnt<=final cnt, state<=IDLE.
//  Detector (Mealy, non-overlapping, 1001):
//   - S0: 1->S1, 0->S0.
//   - S1: 0->S2, 1->S1.
//   - S2: 0->S3, 1->S1.
//   - S3: 1->S0 with match (cnt+1, saturating); 0->S0.
//  Sequence boundaries:
//   - After a match the detector restarts at S0; the final 1 does not seed a new match.
//   - Detector state never carries across words; it is cleared at each grant.
//  Timing:
//   - Grant edge E0. With en=1 throughout, done is high during the cycle after edge E0+WIDTH.
//   - IDLE is re-entered in that same cycle. The next grant can occur at edge E0+WIDTH+1.
//   - Per word: WIDTH+1 cycles plus any en=0 cycles.
//  Requests:
//   - req is sampled only in IDLE. A requester drops req when it sees gnt, or it is treated as a new request.
//   - A req deasserted before its grant is simply not served.
//   - req changes during SHIFT have no effect.
//   - en is ignored in IDLE; arbitration proceeds regardless of en.
//  Reset mid-word: the in-flight word is discarded with no done pulse, and the rr pointer returns to 0.
// TESTING
//  1. req=0001, word0=8'b1001_1001, en=1 -> gnt=0001 1 cycle; done 8 cycles later; done_id=0, match_cnt=2.
//  2. word=8'b1001_0010 (non-overlap check) -> match_cnt=1 (not 2).
//  3. req=1111 held, each req dropped on its gnt -> grant order 0,1,2,3.
//     Then with req=0101 -> order 0,2; done pulses 9 cycles apart.
//  4. word=8'b1001_1001, en=0 for 3 cycles after bit 2 -> done delayed by exactly 3 cycles; match_cnt=2.
//     ser_valid=0 during the stall.
//  5. Cross-word: req1 word 8'b0000_0100 then word 8'b1000_0000 -> both match_cnt=0.
//  6. rst=0 asynchronously mid-SHIFT -> busy/gnt/done/ser_out=0 before the next edge; no done.
//     After release, req=1000 -> grant searched from ptr 0 -> gnt=1000.

Source files
------------

// File: rtl/seq_detect_rr_sched.sv
// Round-robin scheduler sharing one serial non-overlapping "1001" Mealy detector among NREQ requesters.
// Each grant latches a word, shifts it MSB-first through the detector and reports the match count.
module seq_detect_rr_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    ser_out,
  output logic                    ser_valid,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [CNTW-1:0]         match_cnt
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} ctrl_t;
  typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

  ctrl_t            state, state_d;
  det_t             det, det_d;
  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0]   bitcnt;
  logic [CNTW-1:0]  cnt, cnt_d;
  logic [IDW-1:0]   ptr, ptr_nxt, id, win_id;
  logic             win_vld, take, finish, hit;

  logic [WIDTH-1:0] word [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_word
    assign word[g] = data[g*WIDTH +: WIDTH];
  end

  assign busy      = (state == SHIFT);
  assign ser_out   = shreg[WIDTH-1];
  assign ser_valid = busy & en;

  // First requester at or above ptr, wrapping around
  always_comb begin
    int unsigned idx;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_vld && req[IDW'(idx)]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  assign ptr_nxt = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);

  // Control next-state
  always_comb begin
    state_d = state;
    take    = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          take    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (en && bitcnt == BCW'(WIDTH - 1)) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Detector: a trailing 1 that completes a match restarts from S0
  always_comb begin
    det_d = det;
    hit   = 1'b0;
    unique case (det)
      S0: det_d = ser_out ? S1 : S0;
      S1: det_d = ser_out ? S1 : S2;
      S2: det_d = ser_out ? S1 : S3;
      S3: begin
        det_d = S0;
        hit   = ser_out;
      end
      default: det_d = S0;
    endcase
  end

  assign cnt_d = (hit && cnt != '1) ? cnt + CNTW'(1) : cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      det       <= S0;
      shreg     <= '0;
      bitcnt    <= '0;
      cnt       <= '0;
      ptr       <= '0;
      id        <= '0;
      gnt       <= '0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      if (take) begin
        shreg  <= word[win_id];
        gnt    <= NREQ'(1) << win_id;
        id     <= win_id;
        bitcnt <= '0;
        det    <= S0;
        cnt    <= '0;
        ptr    <= ptr_nxt;
      end else if (busy && en) begin
        shreg  <= {shreg[WIDTH-2:0], 1'b0};
        bitcnt <= bitcnt + BCW'(1);
        det    <= det_d;
        cnt    <= cnt_d;
        if (finish) begin
          done      <= 1'b1;
          done_id   <= id;
          match_cnt <= cnt_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_rr_sched.sv
// Bench for seq_detect_rr_sched: word-level reference model checked every cycle, plus directed literal checks.
module tb_seq_detect_rr_sched;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNTW  = 3;
  localparam int unsigned IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  en  = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] data = '0;
  logic [NREQ-1:0]       gnt;
  logic                  busy, ser_out, ser_valid, done;
  logic [IDW-1:0]        done_id;
  logic [CNTW-1:0]       match_cnt;

  seq_detect_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .data(data),
    .gnt(gnt), .busy(busy), .ser_out(ser_out), .ser_valid(ser_valid),
    .done(done), .done_id(done_id), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: word in flight plus number of bits already consumed
  logic             m_busy;
  int               m_k, m_id, m_ptr, m_done_id, m_match;
  logic [WIDTH-1:0] m_word;
  logic [NREQ-1:0]  m_gnt;
  logic             m_done;

  int g_id[$], g_cyc[$], d_id[$], d_cnt[$], d_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Leftmost non-overlapping occurrences of 1001, saturating
  function automatic int count_word(input logic [WIDTH-1:0] w);
    int i = 0;
    int c = 0;
    while (i + 4 <= WIDTH) begin
      if (w[WIDTH-1-i] && !w[WIDTH-2-i] && !w[WIDTH-3-i] && w[WIDTH-4-i]) begin
        c++;
        i += 4;
      end else i++;
    end
    if (c > (1 << CNTW) - 1) c = (1 << CNTW) - 1;
    return c;
  endfunction

  function automatic logic [WIDTH-1:0] word_of(input int i);
    return data[i*WIDTH +: WIDTH];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_word = '0; m_id = 0; m_ptr = 0;
    m_gnt = '0; m_done = 0; m_done_id = 0; m_match = 0;
  endtask

  task automatic model_edge();
    bit found;
    if (!rst) begin
      model_reset();
      return;
    end
    m_gnt  = '0;
    m_done = 0;
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (!found && req[j]) begin
          found  = 1;
          m_id   = j;
          m_word = word_of(j);
          m_gnt  = NREQ'(1) << j;
          m_ptr  = (j + 1) % NREQ;
          m_busy = 1;
          m_k    = 0;
        end
      end
    end else if (en) begin
      m_k++;
      if (m_k == WIDTH) begin
        m_busy    = 0;
        m_done    = 1;
        m_done_id = m_id;
        m_match   = count_word(m_word);
      end
    end
  endtask

  task automatic compare();
    logic exp_ser;
    exp_ser = m_busy ? m_word[WIDTH-1-m_k] : 1'b0;
    chk("outputs{gnt,busy,ser,valid,done,id,cnt}",
        64'({gnt, busy, ser_out, ser_valid, done, done_id, match_cnt}),
        64'({m_gnt, m_busy, exp_ser, m_busy & en, m_done, IDW'(m_done_id), CNTW'(m_match)}));
  endtask

  // One clock: model advances on the edge, DUT is checked mid-cycle, requesters drop on grant
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    compare();
    if (gnt != '0) begin
      for (int i = 0; i < NREQ; i++) if (gnt[i]) g_id.push_back(i);
      g_cyc.push_back(cyc);
    end
    if (done) begin
      d_id.push_back(int'(done_id));
      d_cnt.push_back(int'(match_cnt));
      d_cyc.push_back(cyc);
    end
    req = req & ~m_gnt;
  endtask

  task automatic clear_logs();
    g_id.delete(); g_cyc.delete(); d_id.delete(); d_cnt.delete(); d_cyc.delete();
  endtask

  task automatic wait_dones(input int n, input int budget);
    int t = 0;
    while (d_id.size() < n && t < budget) begin
      cycle();
      t++;
    end
    chk("done_count", 64'(d_id.size()), 64'(n));
  endtask

  task automatic set_word(input int i, input logic [WIDTH-1:0] w);
    data[i*WIDTH +: WIDTH] = w;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    compare();
    chk("reset_outputs", 64'({gnt, busy, ser_out, done, done_id, match_cnt}), 64'(0));
    rst = 1'b1;

    chk("model_1001_1001", 64'(count_word(8'b1001_1001)), 64'(2));
    chk("model_1001_0010", 64'(count_word(8'b1001_0010)), 64'(1));
    chk("model_1000_1001", 64'(count_word(8'b1000_1001)), 64'(1));

    // Round-robin order from ptr 0, then 0,2 with 9-cycle spacing
    en = 1'b1;
    for (int i = 0; i < NREQ; i++) set_word(i, WIDTH'($urandom));
    clear_logs();
    req = 4'b1111;
    wait_dones(4, 60);
    if (g_id.size() == 4) begin
      chk("rr_order0", 64'(g_id[0]), 64'(0));
      chk("rr_order1", 64'(g_id[1]), 64'(1));
      chk("rr_order2", 64'(g_id[2]), 64'(2));
      chk("rr_order3", 64'(g_id[3]), 64'(3));
    end else chk("rr_grant_count", 64'(g_id.size()), 64'(4));
    repeat (2) cycle();
    clear_logs();
    req = 4'b0101;
    wait_dones(2, 40);
    if (d_cyc.size() == 2) begin
      chk("pair_first_id", 64'(d_id[0]), 64'(0));
      chk("pair_second_id", 64'(d_id[1]), 64'(2));
      chk("pair_spacing", 64'(d_cyc[1] - d_cyc[0]), 64'(9));
    end

    // Basic word: two matches, done 8 cycles after gnt
    repeat (2) cycle();
    set_word(0, 8'b1001_1001);
    clear_logs();
    req = 4'b0001;
    wait_dones(1, 30);
    if (d_cnt.size() == 1 && g_cyc.size() == 1) begin
      chk("t1_cnt", 64'(d_cnt[0]), 64'(2));
      chk("t1_id", 64'(d_id[0]), 64'(0));
      chk("t1_latency", 64'(d_cyc[0] - g_cyc[0]), 64'(8));
    end

    // Non-overlap: the closing 1 must not seed a second match
    set_word(0, 8'b1001_0010);
    clear_logs();
    req = 4'b0001;
    wait_dones(1, 30);
    if (d_cnt.size() == 1) chk("t2_cnt", 64'(d_cnt[0]), 64'(1));

    // Three-cycle stall after bit 2
    cycle();
    set_word(0, 8'b1001_1001);
    clear_logs();
    req = 4'b0001;
    cycle();
    repeat (3) cycle();
    en = 1'b0;
    repeat (3) begin
      cycle();
      chk("t4_stall_valid", 64'(ser_valid), 64'(0));
    end
    en = 1'b1;
    wait_dones(1, 30);
    if (d_cnt.size() == 1 && g_cyc.size() == 1) begin
      chk("t4_cnt", 64'(d_cnt[0]), 64'(2));
      chk("t4_latency", 64'(d_cyc[0] - g_cyc[0]), 64'(11));
    end

    // Detector state must not carry between words
    set_word(1, 8'b0000_0100);
    clear_logs();
    req = 4'b0010;
    wait_dones(1, 30);
    set_word(1, 8'b1000_0000);
    req = 4'b0010;
    wait_dones(2, 30);
    if (d_cnt.size() == 2) begin
      chk("t5_cnt_a", 64'(d_cnt[0]), 64'(0));
      chk("t5_cnt_b", 64'(d_cnt[1]), 64'(0));
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int i;
        i = $urandom_range(0, NREQ - 1);
        case ($urandom_range(0, 3))
          0: set_word(i, 8'b1001_1001);
          1: set_word(i, 8'b0100_1001);
          default: set_word(i, WIDTH'($urandom));
        endcase
      end
      en  = ($urandom_range(0, 4) != 0);
      req = req | NREQ'($urandom_range(0, 15) & $urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) req = req & NREQ'($urandom);
      cycle();
    end

    // Asynchronous reset mid-word, then pointer must be back at 0
    req = '0;
    en  = 1'b1;
    repeat (WIDTH + 2) cycle();
    set_word(2, 8'b1001_1001);
    clear_logs();
    req = 4'b0100;
    repeat (4) cycle();
    #2 rst = 1'b0;
    #1;
    chk("rst_async_outputs", 64'({gnt, busy, ser_out, ser_valid, done}), 64'(0));
    model_reset();
    req = 4'b1001;
    cycle();
    chk("rst_no_grant_in_reset", 64'(gnt), 64'(0));
    rst = 1'b1;
    clear_logs();
    cycle();
    chk("rst_ptr_zero_gnt", 64'(gnt), 64'(4'b0001));
    wait_dones(1, 30);
    req = '0;
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
